logic_decode_ctrl: RTL and testbench

LOGIC_DECODE_CTRL -- requirements
Module: logic_decode_ctrl

---
 rtl/logic_decode_ctrl.sv | 108 ++++++++++
 tb/tb_logic_decode_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_decode_ctrl.sv
// rtl/logic_decode_ctrl.sv - decodes logic-op instructions, drives an external logic unit, returns its result
module logic_decode_ctrl #(
    parameter bit ZEXT_IMM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [31:0] log_x,
    output logic [31:0] log_y,
    output logic [2:0]  log_func,
    input  logic [31:0] log_c,
    output logic [31:0] res_data,
    output logic        res_illegal,
    output logic        res_valid,
    input  logic        res_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic        dec_legal;
    logic        dec_rtype;
    logic [2:0]  dec_func;
    logic        accept;
    logic        unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign imm_ext           = ZEXT_IMM ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign unused_instr_bits = ^instr[25:16];

    always_comb begin
        dec_legal = 1'b0;
        dec_rtype = 1'b0;
        dec_func  = 3'b000;
        case (opcode)
            6'b000001: begin
                dec_rtype = 1'b1;
                // R-type funct codes 0..4 line up with the logic-unit function codes
                if (funct <= 6'd4) begin
                    dec_legal = 1'b1;
                    dec_func  = funct[2:0];
                end
            end
            6'b000010: begin dec_legal = 1'b1; dec_func = 3'b000; end
            6'b000011: begin dec_legal = 1'b1; dec_func = 3'b001; end
            6'b000100: begin dec_legal = 1'b1; dec_func = 3'b010; end
            6'b000101: begin dec_legal = 1'b1; dec_func = 3'b011; end
            default: ;
        endcase
    end

    assign instr_ready = (state == IDLE) && !rst;
    assign res_valid   = (state == RESP);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            log_x       <= 32'h0;
            log_y       <= 32'h0;
            log_func    <= 3'b000;
            res_data    <= 32'h0;
            res_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            log_x    <= rs_val;
                            log_y    <= dec_rtype ? rt_val : imm_ext;
                            log_func <= dec_func;
                            state    <= DRIVE;
                        end else begin
                            // illegal ops skip the logic unit and leave its operands alone
                            res_data    <= 32'h0;
                            res_illegal <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    res_data    <= log_c;
                    res_illegal <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_decode_ctrl.sv
// tb/tb_logic_decode_ctrl.sv - scoreboard bench for logic_decode_ctrl, zero- and sign-extend instances
module tb_logic_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        instr_valid = 1'b0;
    logic        res_ready = 1'b0;

    logic        rdy_z, rdy_s, rv_z, rv_s, ill_z, ill_s;
    logic [31:0] x_z, x_s, y_z, y_s, lc_z, lc_s, rd_z, rd_s;
    logic [2:0]  f_z, f_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        legal;
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] yz;
        logic [31:0] ys;
        logic [31:0] dz;
        logic [31:0] ds;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] lop(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a | b);
            3'd3:    return a ^ b;
            3'd4:    return ~a;
            default: return 32'h0;
        endcase
    endfunction

    assign lc_z = lop(x_z, y_z, f_z);
    assign lc_s = lop(x_s, y_s, f_s);

    logic_decode_ctrl #(.ZEXT_IMM(1'b1)) u_z (
        .clk(clk), .rst(rst), .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .instr_valid(instr_valid), .instr_ready(rdy_z), .log_x(x_z), .log_y(y_z),
        .log_func(f_z), .log_c(lc_z), .res_data(rd_z), .res_illegal(ill_z),
        .res_valid(rv_z), .res_ready(res_ready)
    );

    logic_decode_ctrl #(.ZEXT_IMM(1'b0)) u_s (
        .clk(clk), .rst(rst), .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .instr_valid(instr_valid), .instr_ready(rdy_s), .log_x(x_s), .log_y(y_s),
        .log_func(f_s), .log_c(lc_s), .res_data(rd_s), .res_illegal(ill_s),
        .res_valid(rv_s), .res_ready(res_ready)
    );

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        op      = ins[31:26];
        fn      = ins[5:0];
        e.legal = 1'b0;
        e.f     = 3'd0;
        e.x     = rs;
        e.yz    = rt;
        e.ys    = rt;
        if (op == 6'd1 && fn <= 6'd4) begin
            e.legal = 1'b1;
            e.f     = fn[2:0];
        end else if (op >= 6'd2 && op <= 6'd5) begin
            e.legal = 1'b1;
            e.f     = op[2:0] - 3'd2;
            e.yz    = {16'h0000, ins[15:0]};
            e.ys    = {{16{ins[15]}}, ins[15:0]};
        end
        e.dz = e.legal ? lop(rs, e.yz, e.f) : 32'h0;
        e.ds = e.legal ? lop(rs, e.ys, e.f) : 32'h0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr(input bit legal);
        logic [31:0] r;
        int          k;
        r = $urandom;
        if (legal) begin
            k = $urandom_range(0, 8);
            if (k < 5) return {6'd1, r[19:0], 6'(k)};
            return {6'(k - 3), r[25:0]};
        end
        if (r[31]) return {6'd1, r[19:0], 6'($urandom_range(5, 63))};
        return {6'($urandom_range(6, 63)), r[25:0]};
    endfunction

    task automatic issue(input string name, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input int hold);
        exp_t        e;
        exp_t        g;
        logic [66:0] prev;
        int          lat;
        e = model(ins, rs, rt);
        sbq.push_back(e);
        @(negedge clk);
        prev        = {x_z, y_z, f_z};
        instr       = ins;
        rs_val      = rs;
        rt_val      = rt;
        instr_valid = 1'b1;
        res_ready   = 1'b0;
        checks++;
        if ({rdy_z, rdy_s} !== 2'b11) begin
            errors++;
            $display("FAIL %s ready: got %b expected 11", name, {rdy_z, rdy_s});
        end
        @(posedge clk);
        #1;
        instr  = $urandom;
        rs_val = $urandom;
        rt_val = $urandom;
        checks++;
        if (e.legal) begin
            if ({x_z, y_z, f_z, y_s} !== {e.x, e.yz, e.f, e.ys}) begin
                errors++;
                $display("FAIL %s operands: got x=%h yz=%h f=%b ys=%h expected x=%h yz=%h f=%b ys=%h",
                         name, x_z, y_z, f_z, y_s, e.x, e.yz, e.f, e.ys);
            end
        end else if ({x_z, y_z, f_z} !== prev) begin
            errors++;
            $display("FAIL %s operands_held: got %h expected %h", name, {x_z, y_z, f_z}, prev);
        end
        lat = 1;
        while (rv_z !== 1'b1 && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != (e.legal ? 2 : 1)) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, e.legal ? 2 : 1);
        end
        if (sbq.size() > 0) begin
            g = sbq.pop_front();
            checks++;
            if ({rv_s, rd_z, ill_z, rd_s, ill_s} !== {1'b1, g.dz, ~g.legal, g.ds, ~g.legal}) begin
                errors++;
                $display("FAIL %s result: got vs=%b dz=%h iz=%b ds=%h is=%b expected dz=%h ds=%h ill=%b",
                         name, rv_s, rd_z, ill_z, rd_s, ill_s, g.dz, g.ds, ~g.legal);
            end
            repeat (hold) begin
                @(posedge clk);
                #1;
                checks++;
                if ({rv_z, rdy_z, rdy_s, rd_z, ill_z, rd_s} !== {1'b1, 2'b00, g.dz, ~g.legal, g.ds}) begin
                    errors++;
                    $display("FAIL %s hold: got v=%b r=%b%b d=%h i=%b expected v=1 r=00 d=%h i=%b",
                             name, rv_z, rdy_z, rdy_s, rd_z, ill_z, g.dz, ~g.legal);
                end
            end
        end
        @(negedge clk);
        res_ready   = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checks++;
        if ({rv_z, rv_s, rdy_z, rdy_s} !== 4'b0011) begin
            errors++;
            $display("FAIL %s release: got %b expected 0011", name, {rv_z, rv_s, rdy_z, rdy_s});
        end
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy_z, rv_z, ill_z, rd_z, x_z, y_z, f_z, rdy_s, rv_s, ill_s, rd_s, x_s, y_s, f_s} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h x=%h y=%h f=%b expected all 0",
                     rdy_z, rv_z, rd_z, x_z, y_z, f_z);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rdy_z, rdy_s, rv_z, rv_s} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: got %b expected 1100", {rdy_z, rdy_s, rv_z, rv_s});
        end
    endtask

    task automatic test_vectors;
        issue("andi", {6'b000010, 10'd0, 16'h0F0F}, 32'hFFFF00FF, 32'hDEADBEEF, 1);
        checks++;
        if ({rd_z, y_z, f_z, ill_z} !== {32'h0000000F, 32'h00000F0F, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL andi_const: got d=%h y=%h f=%b expected d=0000000f y=00000f0f f=000", rd_z, y_z, f_z);
        end
        issue("nor", {6'b000001, 20'd0, 6'b000010}, 32'hF0F0F0F0, 32'h0F0F0F00, 0);
        checks++;
        if ({rd_z, f_z, ill_z} !== {32'h0000000F, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL nor_const: got d=%h f=%b i=%b expected d=0000000f f=010 i=0", rd_z, f_z, ill_z);
        end
        issue("not", {6'b000001, 20'd0, 6'b000100}, 32'h12345678, 32'h00000000, 0);
        checks++;
        if ({rd_z, f_z} !== {32'hEDCBA987, 3'b100}) begin
            errors++;
            $display("FAIL not_const: got d=%h f=%b expected d=edcba987 f=100", rd_z, f_z);
        end
        issue("ori_sext", {6'b000011, 10'd0, 16'h8000}, 32'h00000000, 32'h00000000, 0);
        checks++;
        if ({y_s, rd_s, y_z, rd_z} !== {32'hFFFF8000, 32'hFFFF8000, 32'h00008000, 32'h00008000}) begin
            errors++;
            $display("FAIL ori_const: got ys=%h ds=%h yz=%h dz=%h expected ys=ffff8000 ds=ffff8000 yz=00008000 dz=00008000",
                     y_s, rd_s, y_z, rd_z);
        end
        issue("illegal_op", {6'b111111, 26'h155AA}, 32'h11111111, 32'h22222222, 5);
        checks++;
        if ({rd_z, ill_z} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_const: got d=%h i=%b expected d=0 i=1", rd_z, ill_z);
        end
        issue("illegal_funct", {6'b000001, 20'd0, 6'b000101}, 32'h33333333, 32'h44444444, 1);
        issue("illegal_op0", 32'h0000_0000, 32'h55555555, 32'h66666666, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            issue("random", rand_instr(i[0]), $urandom, $urandom, $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back(input bit legal, input int cycles, input int exp_res);
        exp_t g;
        int   nres;
        nres      = 0;
        res_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (rv_z === 1'b1) begin
                nres++;
                if (sbq.size() > 0) begin
                    g = sbq.pop_front();
                    checks++;
                    if ({rd_z, ill_z, rd_s} !== {g.dz, ~g.legal, g.ds}) begin
                        errors++;
                        $display("FAIL b2b_result: got dz=%h i=%b ds=%h expected dz=%h i=%b ds=%h",
                                 rd_z, ill_z, rd_s, g.dz, ~g.legal, g.ds);
                    end
                end
            end
            instr       = rand_instr(legal);
            rs_val      = $urandom;
            rt_val      = $urandom;
            instr_valid = 1'b1;
            if (rdy_z === 1'b1) sbq.push_back(model(instr, rs_val, rt_val));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        res_ready   = 1'b0;
        checks++;
        if (nres != exp_res || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d results, %0d pending expected %0d results, 0 pending",
                     nres, sbq.size(), exp_res);
        end
        sbq.delete();
    endtask

    task automatic test_reset_midop;
        int stale;
        @(negedge clk);
        instr       = {6'b000001, 20'd0, 6'b000011};
        rs_val      = 32'hA5A5A5A5;
        rt_val      = 32'h0F0F0F0F;
        instr_valid = 1'b1;
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
        rst         = 1'b1;
        #1;
        checks++;
        if ({rdy_z, rv_z, ill_z, rd_z, x_z, y_z, f_z, rv_s, x_s} !== '0) begin
            errors++;
            $display("FAIL reset_midop: got rdy=%b v=%b d=%h x=%h y=%h f=%b expected all 0",
                     rdy_z, rv_z, rd_z, x_z, y_z, f_z);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({rdy_z, rdy_s, rv_z, rv_s} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_midop_release: got %b expected 1100", {rdy_z, rdy_s, rv_z, rv_s});
        end
        stale = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rv_z !== 1'b0 || rv_s !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_midop_stale: got %0d valid cycles expected 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back(1'b1, 9, 3);
        test_back_to_back(1'b0, 8, 4);
        test_reset_midop();
        issue("after_reset", {6'b000101, 10'd0, 16'hFFFF}, 32'h0000FFFF, 32'h0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
